shift_ctrl: RTL and testbench
=============================

Name: shift_ctrl

Overview:
- Sequencer for the Fredkin-clock-gated serial shift chain (DEPTH DFF stages, each stage clocked through a Fredkin controlled-swap gate).
- Accepts a parallel word on a valid/ready handshake and drives the chain LSB-first through `si`.
- Generates the chain's gating enable, `shift_en`.
- Reassembles the word from `so` and presents it on a valid/ready output.
- Used for loopback and bring-up of the reversible-logic sequential datapath.

Parameters:
- WIDTH, 8, bits per frame (≥1).
- DEPTH, 4, number of stages in the controlled shift chain (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  WIDTH  word to serialise.
- shift_en  output  1  chain clock-gate control; the chain advances one stage on every clk edge where shift_en=1.
- si  output  1  serial data into chain stage 1.
- so  input  1  serial data from chain stage DEPTH.
- out_valid  output  1  reassembled word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  reassembled word.
- busy  output  1  high in SHIFT or HOLD.

Behaviour:
- Reset (asynchronous, any state, mid-frame included):
  - State = IDLE, counter = 0.
  - shift_en=0, si=0, out_valid=0, out_data=0, busy=0, in_ready=1 once rst deasserts.
  - The partially shifted frame is discarded. Chain contents are not reset; see sampling rule.
- States: IDLE, SHIFT, HOLD.
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches in_data into the tx register and moves to SHIFT with counter c=0.
  - SHIFT: shift_en=1 for exactly WIDTH+DEPTH consecutive cycles, c=0..WIDTH+DEPTH-1.
    - si = tx[c] for c<WIDTH; si=0 for c≥WIDTH (flush).
    - At the edge ending cycle c with c≥DEPTH, rx[c-DEPTH] <= so.
    - Bits present in the chain before the frame are never sampled.
    - After c=WIDTH+DEPTH-1, move to HOLD with out_data=rx and out_valid=1.
  - HOLD: shift_en=0; out_valid=1 and out_data stable until out_ready.
    - in_ready = out_ready.
    - out_ready & in_valid in the same cycle: the output is consumed, the new word is latched, and the next state is SHIFT (back-to-back frames, zero bubble).
    - out_ready without in_valid: next state is IDLE.
- Latency: handshake edge → out_valid high after WIDTH+DEPTH+1 cycles.
  - Frame period with continuous flow: WIDTH+DEPTH+1 cycles.
- in_ready=0 throughout SHIFT; in_valid is ignored there.
- shift_en and si are registered outputs (glitch-free gate control). No combinational path from so to any output.
- Counter width: clog2(WIDTH+DEPTH+1). The counter must not wrap within a frame.
- DEPTH=1 and WIDTH=1 are legal. Behaviour follows the same formulas.

Decomposition:
- Package shift_ctrl_pkg holds:
  - the state enum (IDLE, SHIFT, HOLD);
  - default WIDTH/DEPTH constants;
  - a function computing counter width from WIDTH+DEPTH.
- One sub-module, shift_ctrl_cnt: frame counter with clear, enable and terminal-count output (c==WIDTH+DEPTH-1), asynchronous active-high reset.
- The bench instantiates shift_ctrl against a behavioural DEPTH-stage enable-gated chain, so the check is end-to-end.

Test Plan (all scenarios WIDTH=8, DEPTH=4):
1. Single frame: in_data=0xA5, out_ready=1 → shift_en high exactly 12 cycles; si sequence 1,0,1,0,0,1,0,1,0,0,0,0; out_data=0xA5, out_valid pulses 1 cycle, 13 cycles after the handshake.
2. Chain preloaded with 1s (0xF, shifted in before the first frame), then frame 0x00 → out_data=0x00, proving no stale bits are sampled.
3. Back-to-back: in_valid held, words 0x3C then 0xC3, out_ready=1 → outputs 0x3C and 0xC3; frame period 13 cycles; no idle cycle between frames.
4. Backpressure: out_ready=0 for 20 cycles after 0x5A completes → out_valid stays 1, out_data stays 0x5A, shift_en=0, in_ready=0; out_ready=1 with in_valid=1 → 0x5A consumed and the new word accepted on the same edge.
5. Reset mid-frame: rst pulsed at c=6 of frame 0xFF → all outputs 0 immediately (asynchronous); next frame 0x81 returns 0x81 correctly.
6. Parameter corners WIDTH=1, DEPTH=1: frame 1 → shift_en high 2 cycles, out_data=1; frame 0 → out_data=0.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl_pkg
// Purpose  : Shared types and helpers for the shift-chain sequencer.
//            State encoding, default frame/chain sizes, counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int C_DEF_WIDTH = 8;
    localparam int C_DEF_DEPTH = 4;

    // Counter must be able to hold n (one past the terminal value n-1)
    // so that the final increment of a frame never wraps.
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl_cnt
// Purpose  : Frame cycle counter with synchronous clear, count enable and a
//            terminal-count flag.
// Ports    : clk, rst (async, active-high), clr, en -> count, tc
//            tc is high while count == TERMINAL.
// Revision : 1.0 - initial release
// ============================================================================
module shift_ctrl_cnt #(
    parameter int CW       = 4,
    parameter int TERMINAL = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(TERMINAL));

endmodule
`default_nettype wire

// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl
// Purpose  : Sequencer for a clock-gated serial shift chain. Accepts a word on
//            in_valid/in_ready, streams it LSB-first into the chain (si) with
//            the gate enable (shift_en) raised for WIDTH+DEPTH cycles, then
//            rebuilds the word from the chain output (so) and offers it on
//            out_valid/out_ready.
// Ports    : clk, rst (async, active-high)
//            in_valid, in_ready, in_data[WIDTH]   - word input
//            shift_en, si, so                     - chain interface
//            out_valid, out_ready, out_data[WIDTH]- word output
//            busy                                 - high in SHIFT or HOLD
// Revision : 1.0 - initial release
// ============================================================================
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int DEPTH = C_DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             shift_en,
    output logic             si,
    input  logic             so,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int C_CW = cnt_width(WIDTH + DEPTH);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-1:0]   r_rx;
    logic [WIDTH-1:0]   w_rx_next;
    logic [C_CW-1:0]    w_count;
    logic               w_tc;
    logic               w_accept;
    logic               w_sample;

    assign w_accept = in_valid & in_ready;
    // A bit driven at cycle c reaches the chain output during cycle c+DEPTH,
    // so the first DEPTH cycles of a frame only see pre-frame contents.
    assign w_sample = (r_state == SHIFT) && (w_count >= C_CW'(DEPTH));

    shift_ctrl_cnt #(
        .CW       (C_CW),
        .TERMINAL (WIDTH + DEPTH - 1)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .en    (r_state == SHIFT),
        .count (w_count),
        .tc    (w_tc)
    );

    // Receive shifter: newest sample enters at the MSB, so after WIDTH
    // samples the first one received sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_rx_single
            assign w_rx_next = so;
        end else begin : g_rx_multi
            assign w_rx_next = {so, r_rx[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_tc) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                busy     = 1'b1;
                in_ready = out_ready;
                if (out_ready) begin
                    w_next = in_valid ? SHIFT : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // shift_en and si are registered from the next-state decision so the
    // chain gate sees a clean, edge-aligned control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_en  <= 1'b0;
            si        <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            shift_en <= (w_next == SHIFT);

            if (w_accept) begin
                si   <= in_data[0];
                r_tx <= in_data >> 1;
            end else if (r_state == SHIFT) begin
                // Zero-filled shift provides the flush bits after the word.
                si   <= r_tx[0];
                r_tx <= r_tx >> 1;
            end

            if (w_sample) begin
                r_rx <= w_rx_next;
            end

            if ((r_state == SHIFT) && w_tc) begin
                out_data  <= w_rx_next;
                out_valid <= 1'b1;
            end else if ((r_state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_ctrl
// Purpose  : Self-checking bench for shift_ctrl, closing the loop through a
//            behavioural enable-gated shift chain. Covers WIDTH=8/DEPTH=4 and
//            the WIDTH=1/DEPTH=1 corner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- WIDTH=8, DEPTH=4 instance ----------------
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready, shift_en, si, so, out_valid, busy;
    logic [7:0] out_data;
    logic [3:0] chain;
    logic       pre_en = 1'b0;

    shift_ctrl #(.WIDTH(8), .DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .shift_en(shift_en), .si(si), .so(so),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    // Chain is never reset; pre_en lets the bench stuff 1s while idle.
    always @(posedge clk) begin
        if (shift_en)    chain <= {chain[2:0], si};
        else if (pre_en) chain <= {chain[2:0], 1'b1};
    end
    assign so = chain[3];

    // ---------------- WIDTH=1, DEPTH=1 instance ----------------
    logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [0:0] in_data1  = 1'b0;
    logic       in_ready1, shift_en1, si1, so1, out_valid1, busy1;
    logic [0:0] out_data1;
    logic       chain1;

    shift_ctrl #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .shift_en(shift_en1), .si(si1), .so(so1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1)
    );

    always @(posedge clk) if (shift_en1) chain1 <= si1;
    assign so1 = chain1;

    // Drive one frame on dut0 with out_ready=1; lat counts edges from the
    // handshake edge (inclusive) to the first out_valid sample.
    task automatic run_frame0(input logic [7:0] d, output logic [7:0] got,
                              output int lat, output int sen, output int nov,
                              output logic [15:0] siv);
        in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        got = 8'h00; lat = -1; sen = 0; nov = 0; siv = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) in_valid = 1'b0;
            if (shift_en) begin
                siv[sen] = si;
                sen++;
            end
            if (out_valid) begin
                nov++;
                if (lat < 0) begin lat = i; got = out_data; end
            end
        end
    endtask

    task automatic run_frame1(input logic d, output logic got,
                              output int lat, output int sen);
        in_data1 = d; in_valid1 = 1'b1; out_ready1 = 1'b1;
        got = 1'b0; lat = -1; sen = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) in_valid1 = 1'b0;
            if (shift_en1) sen++;
            if (out_valid1 && lat < 0) begin lat = i; got = out_data1[0]; end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({shift_en, si, out_valid, out_data, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=000", {shift_en, si, out_valid, out_data, busy});
        end
        checks++;
        if ({shift_en1, si1, out_valid1, out_data1, busy1} !== 5'h00) begin
            failures++;
            $display("FAIL reset_outputs_w1 got=%h exp=00", {shift_en1, si1, out_valid1, out_data1, busy1});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b%b exp=11", in_ready, in_ready1);
        end
    endtask

    task automatic test_single();
        logic [7:0] got; int lat, sen, nov; logic [15:0] siv;
        run_frame0(8'hA5, got, lat, sen, nov, siv);
        checks++;
        if (sen !== 12) begin failures++; $display("FAIL single_shift_cycles got=%0d exp=12", sen); end
        checks++;
        if (siv[11:0] !== 12'h0A5) begin failures++; $display("FAIL single_si_seq got=%h exp=0a5", siv[11:0]); end
        checks++;
        if (got !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", got); end
        checks++;
        if (lat !== 13) begin failures++; $display("FAIL single_latency got=%0d exp=13", lat); end
        checks++;
        if (nov !== 1) begin failures++; $display("FAIL single_valid_pulse got=%0d exp=1", nov); end
    endtask

    task automatic test_stale();
        logic [7:0] got; int lat, sen, nov; logic [15:0] siv;
        pre_en = 1'b1;
        repeat (4) @(posedge clk);
        #1; pre_en = 1'b0;
        checks++;
        if (chain !== 4'hF) begin failures++; $display("FAIL stale_preload got=%h exp=f", chain); end
        run_frame0(8'h00, got, lat, sen, nov, siv);
        checks++;
        if (got !== 8'h00) begin failures++; $display("FAIL stale_data got=%h exp=00", got); end
    endtask

    task automatic test_back_to_back();
        int nv = 0, t1 = -1, t2 = -1;
        logic [7:0] d1 = 8'h00, d2 = 8'h00;
        logic drop = 1'b0;
        in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = 8'hC3;
        for (int i = 2; i <= 60; i++) begin
            @(posedge clk); #1;
            if (drop) begin
                in_valid = 1'b0; drop = 1'b0;
                checks++;
                if (shift_en !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got=%b exp=1", shift_en); end
            end
            if (out_valid) begin
                nv++;
                if (nv == 1) begin t1 = i; d1 = out_data; drop = 1'b1; end
                else if (nv == 2) begin t2 = i; d2 = out_data; end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (d1 !== 8'h3C || d2 !== 8'hC3) begin failures++; $display("FAIL b2b_data got=%h,%h exp=3c,c3", d1, d2); end
        checks++;
        if (t1 !== 13) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=13", t1); end
        checks++;
        if (t2 - t1 !== 13) begin failures++; $display("FAIL b2b_period got=%0d exp=13", t2 - t1); end
    endtask

    task automatic test_backpressure();
        int waited = 0;
        logic [7:0] got; int lat, sen, nov; logic [15:0] siv;
        in_data = 8'h5A; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && waited < 40) begin @(posedge clk); #1; waited++; end
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
        in_data = 8'h66; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_data, shift_en, in_ready} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h en=%b rdy=%b exp v=1 d=5a en=0 rdy=0",
                         i, out_valid, out_data, shift_en, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_follow got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || shift_en !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got v=%b en=%b exp v=0 en=1", out_valid, shift_en);
        end
        waited = 0;
        while (!out_valid && waited < 40) begin @(posedge clk); #1; waited++; end
        checks++;
        if (out_data !== 8'h66 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_next_word got=%h v=%b exp=66 v=1", out_data, out_valid);
        end
        @(posedge clk); #1;
        // Let the output complete with nothing further queued.
        repeat (2) @(posedge clk);
        #1;
        // Discard any leftover state from the frame above.
        got = 8'h00; lat = 0; sen = 0; nov = 0; siv = '0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got; int lat, sen, nov; logic [15:0] siv;
        in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (shift_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset got en=%b busy=%b exp en=1 busy=1", shift_en, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({shift_en, si, out_valid, out_data, busy} !== 12'h000) begin
            failures++;
            $display("FAIL mid_async_reset got=%h exp=000", {shift_en, si, out_valid, out_data, busy});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle got rdy=%b busy=%b exp rdy=1 busy=0", in_ready, busy);
        end
        run_frame0(8'h81, got, lat, sen, nov, siv);
        checks++;
        if (got !== 8'h81 || lat !== 13) begin
            failures++;
            $display("FAIL mid_next_frame got=%h lat=%0d exp=81 lat=13", got, lat);
        end
    endtask

    task automatic test_corner();
        logic got; int lat, sen;
        run_frame1(1'b1, got, lat, sen);
        checks++;
        if (sen !== 2) begin failures++; $display("FAIL w1_shift_cycles got=%0d exp=2", sen); end
        checks++;
        if (got !== 1'b1 || lat !== 3) begin failures++; $display("FAIL w1_frame1 got=%b lat=%0d exp=1 lat=3", got, lat); end
        run_frame1(1'b0, got, lat, sen);
        checks++;
        if (got !== 1'b0 || lat !== 3) begin failures++; $display("FAIL w1_frame0 got=%b lat=%0d exp=0 lat=3", got, lat); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
